// File: rtl/cache_flush_unit.sv
// Cache flush engine: walks all 8 lines in index order and writes every dirty
// line back to physical memory, clearing its dirty bit once memory acknowledges.
module cache_flush_unit #(
   parameter int width     = 128,
   parameter int num_lines = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 flush_req,
   output logic                 busy,
   output logic                 flush_done,
   output logic [2:0]           array_index,
   input  logic [width-1:0]     array_dataout,
   input  logic [8:0]           tag_in,
   input  logic [num_lines-1:0] dirty,
   output logic                 clear_dirty,
   output logic [15:0]          pmem_address,
   output logic [width-1:0]     pmem_wdata,
   output logic                 pmem_write,
   input  logic                 pmem_resp
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SCAN  = 3'd1,
      ST_WRITE = 3'd2,
      ST_CLEAR = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [2:0]       r_idx;
   logic [2:0]       w_next_idx;
   logic             w_latch;
   logic [15:0]      r_addr;
   logic [width-1:0] r_wdata;

   // State, line counter and the write-back address/data latched when a dirty line is found
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_idx   <= 3'd0;
         r_addr  <= {16{1'b0}};
         r_wdata <= {width{1'b0}};
      end else begin
         r_state <= w_next_state;
         r_idx   <= w_next_idx;
         if (w_latch) begin
            r_addr  <= {tag_in, r_idx, 4'b0000};
            r_wdata <= array_dataout;
         end else begin
            r_addr  <= r_addr;
            r_wdata <= r_wdata;
         end
      end
   end

   // Next-state and counter logic; index 7 always exits to DONE so the counter never wraps
   always_comb begin
      w_next_state = r_state;
      w_next_idx   = r_idx;
      w_latch      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (flush_req) begin
               w_next_state = ST_SCAN;
               w_next_idx   = 3'd0;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (dirty[r_idx]) begin
               w_next_state = ST_WRITE;
               w_latch      = 1'b1;
            end else if (r_idx == 3'd7) begin
               w_next_state = ST_DONE;
            end else begin
               w_next_idx   = r_idx + 3'd1;
            end
         end
         ST_WRITE: begin
            if (pmem_resp) begin
               w_next_state = ST_CLEAR;
            end else begin
               w_next_state = ST_WRITE;
            end
         end
         ST_CLEAR: begin
            if (r_idx == 3'd7) begin
               w_next_state = ST_DONE;
            end else begin
               w_next_state = ST_SCAN;
               w_next_idx   = r_idx + 3'd1;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
            w_next_idx   = 3'd0;
         end
      endcase
   end

   // Moore strobes decoded from the state register only
   always_comb begin
      busy        = 1'b0;
      flush_done  = 1'b0;
      clear_dirty = 1'b0;
      pmem_write  = 1'b0;
      case (r_state)
         ST_IDLE:  busy = 1'b0;
         ST_SCAN:  busy = 1'b1;
         ST_WRITE: begin
            busy       = 1'b1;
            pmem_write = 1'b1;
         end
         ST_CLEAR: begin
            busy        = 1'b1;
            clear_dirty = 1'b1;
         end
         ST_DONE: begin
            busy       = 1'b1;
            flush_done = 1'b1;
         end
         default:  busy = 1'b0;
      endcase
   end

   assign array_index  = r_idx;
   assign pmem_address = r_addr;
   assign pmem_wdata   = r_wdata;

endmodule

// File: tb/tb_cache_flush_unit.sv
// Self-checking bench for cache_flush_unit: a small array/memory model drives the
// DUT while expected write-backs and timing come from a line-by-line reference model.
module tb_cache_flush_unit;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         flush_req;
   logic         busy;
   logic         flush_done;
   logic [2:0]   array_index;
   logic [127:0] array_dataout;
   logic [8:0]   tag_in;
   logic [7:0]   dirty_bits;
   logic         clear_dirty;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic         pmem_write;
   logic         pmem_resp;

   logic [8:0]   tag_mem [8];
   logic [127:0] data_mem [8];

   int checks = 0;
   int errors = 0;

   // observations of one flush
   logic [15:0]  obs_addr [$];
   logic [127:0] obs_data [$];
   int           obs_clr [$];
   int tot_w, done_cyc, done_cnt, busy_gap, unstable, first_idx;
   logic post_busy, post_done;

   // reference expectations of one flush
   logic [15:0]  exp_addr [$];
   logic [127:0] exp_data [$];
   int           exp_clr [$];
   int exp_cyc, exp_w;

   cache_flush_unit #(.width(128), .num_lines(8)) dut (
      .clk(clk), .reset_n(reset_n), .flush_req(flush_req), .busy(busy),
      .flush_done(flush_done), .array_index(array_index), .array_dataout(array_dataout),
      .tag_in(tag_in), .dirty(dirty_bits), .clear_dirty(clear_dirty),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_write(pmem_write),
      .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   assign tag_in        = tag_mem[array_index];
   assign array_dataout = data_mem[array_index];

   task automatic fill_random();
      for (int i = 0; i < 8; i++) begin
         tag_mem[i]  = 9'($urandom_range(0, 511));
         data_mem[i] = {$urandom, $urandom, $urandom, $urandom};
      end
   endtask

   // Expected behaviour: lines visited 0..7; a clean line costs one cycle, a dirty
   // line costs scan + lat write cycles + clear; flush_done is the cycle after that.
   task automatic model_flush(input int lat);
      exp_addr.delete(); exp_data.delete(); exp_clr.delete();
      exp_cyc = 1;
      exp_w   = 0;
      for (int i = 0; i < 8; i++) begin
         if (dirty_bits[i]) begin
            exp_addr.push_back(16'(tag_mem[i]) * 16'd128 + 16'(i * 16));
            exp_data.push_back(data_mem[i]);
            exp_clr.push_back(i);
            exp_cyc += lat + 2;
            exp_w   += lat;
         end else begin
            exp_cyc += 1;
         end
      end
   endtask

   // Pulses flush_req, plays memory with a fixed ack latency, records what the DUT did.
   task automatic do_flush(input int lat, input bit noise, input bit req_noise);
      int wcnt;
      bit fin;
      logic [15:0]  cur_a;
      logic [127:0] cur_d;
      obs_addr.delete(); obs_data.delete(); obs_clr.delete();
      tot_w = 0; done_cyc = 0; done_cnt = 0; busy_gap = 0; unstable = 0;
      first_idx = -1; wcnt = 0; fin = 1'b0;
      cur_a = 16'h0000; cur_d = '0;
      @(negedge clk);
      flush_req = 1'b1;
      pmem_resp = 1'b0;
      for (int c = 1; c <= 600 && !fin; c++) begin
         @(negedge clk);
         if (c == 1) first_idx = int'(array_index);
         if (busy !== 1'b1) busy_gap++;
         if (pmem_write === 1'b1) begin
            if (wcnt == 0) begin
               cur_a = pmem_address;
               cur_d = pmem_wdata;
               obs_addr.push_back(cur_a);
               obs_data.push_back(cur_d);
            end else if (pmem_address !== cur_a || pmem_wdata !== cur_d) begin
               unstable++;
            end
            wcnt++;
            tot_w++;
            pmem_resp = (wcnt >= lat) ? 1'b1 : 1'b0;
         end else begin
            wcnt = 0;
            pmem_resp = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         if (clear_dirty === 1'b1) begin
            obs_clr.push_back(int'(array_index));
            dirty_bits[array_index] = 1'b0;
         end
         if (flush_done === 1'b1) begin
            done_cnt++;
            done_cyc  = c;
            fin       = 1'b1;
            flush_req = 1'b0;
         end else begin
            flush_req = req_noise ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
      pmem_resp = 1'b0;
      flush_req = 1'b0;
      @(negedge clk);
      post_busy = busy;
      post_done = flush_done;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; flush_req = 1'b0; pmem_resp = 1'b0; dirty_bits = 8'h00;
      fill_random();
      #12;
      checks++;
      if ({busy, flush_done, clear_dirty, pmem_write} !== 4'b0000) begin
         errors++; $display("FAIL reset_strobes got %b expected 0000", {busy, flush_done, clear_dirty, pmem_write});
      end
      checks++;
      if (pmem_address !== 16'h0000 || array_index !== 3'd0) begin
         errors++; $display("FAIL reset_addr got %h/%0d expected 0000/0", pmem_address, array_index);
      end
      checks++;
      if (pmem_wdata !== 128'd0) begin
         errors++; $display("FAIL reset_wdata got %h expected 0", pmem_wdata);
      end
      @(negedge clk);
      reset_n = 1'b1;
      busy_gap = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (busy !== 1'b0) busy_gap++;
      end
      checks++;
      if (busy_gap !== 0) begin
         errors++; $display("FAIL reset_stays_idle got %0d busy cycles expected 0", busy_gap);
      end
   endtask

   task automatic test_clean();
      dirty_bits = 8'h00;
      model_flush(1);
      do_flush(1, 1'b1, 1'b0);
      checks++;
      if (obs_addr.size() !== 0 || obs_clr.size() !== 0 || tot_w !== 0) begin
         errors++; $display("FAIL clean_no_writes got %0d writes %0d clears expected 0 0", obs_addr.size(), obs_clr.size());
      end
      // ninth cycle after the sampling edge
      checks++;
      if (done_cyc !== 9 || exp_cyc !== 9) begin
         errors++; $display("FAIL clean_done_cycle got %0d expected 9", done_cyc);
      end
      checks++;
      if (busy_gap !== 0 || post_busy !== 1'b0 || post_done !== 1'b0) begin
         errors++; $display("FAIL clean_busy got gap %0d post_busy %b post_done %b expected 0 0 0", busy_gap, post_busy, post_done);
      end
   endtask

   task automatic test_single_dirty();
      fill_random();
      dirty_bits  = 8'b0000_0100;
      tag_mem[2]  = 9'h1A5;
      data_mem[2] = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
      model_flush(3);
      do_flush(3, 1'b0, 1'b0);
      checks++;
      if (obs_addr.size() !== 1 || obs_addr[0] !== 16'hD2A0) begin
         errors++; $display("FAIL single_addr got %0d writes addr %h expected 1 d2a0", obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : 16'h0);
      end
      checks++;
      if (obs_data.size() !== 1 || obs_data[0] !== 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF) begin
         errors++; $display("FAIL single_data got %0d writes expected 1 with dead..beef", obs_data.size());
      end
      checks++;
      if (tot_w !== 3 || unstable !== 0) begin
         errors++; $display("FAIL single_write_len got %0d cycles %0d unstable expected 3 0", tot_w, unstable);
      end
      checks++;
      if (obs_clr.size() !== 1 || obs_clr[0] !== 2) begin
         errors++; $display("FAIL single_clear got %0d clears expected 1 at index 2", obs_clr.size());
      end
      checks++;
      if (done_cyc !== exp_cyc || done_cnt !== 1) begin
         errors++; $display("FAIL single_done got cycle %0d count %0d expected %0d 1", done_cyc, done_cnt, exp_cyc);
      end
   endtask

   task automatic test_all_dirty();
      fill_random();
      dirty_bits = 8'hFF;
      model_flush(1);
      do_flush(1, 1'b0, 1'b0);
      checks++;
      if (obs_addr.size() !== 8 || obs_clr.size() !== 8) begin
         errors++; $display("FAIL all_counts got %0d writes %0d clears expected 8 8", obs_addr.size(), obs_clr.size());
      end
      for (int i = 0; i < 8 && i < obs_addr.size() && i < obs_clr.size(); i++) begin
         checks++;
         if (obs_addr[i] !== exp_addr[i] || obs_clr[i] !== i) begin
            errors++; $display("FAIL all_order[%0d] got addr %h clr %0d expected %h %0d", i, obs_addr[i], obs_clr[i], exp_addr[i], i);
         end
      end
      checks++;
      if (done_cyc !== 25 || done_cnt !== 1 || post_done !== 1'b0 || post_busy !== 1'b0) begin
         errors++; $display("FAIL all_done got cycle %0d count %0d post %b/%b expected 25 1 0/0", done_cyc, done_cnt, post_done, post_busy);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         int lat;
         fill_random();
         dirty_bits = 8'($urandom_range(0, 255));
         lat = int'($urandom_range(1, 4));
         model_flush(lat);
         do_flush(lat, 1'b1, 1'b1);
         checks++;
         if (obs_addr.size() !== exp_addr.size() || obs_clr.size() !== exp_clr.size()) begin
            errors++; $display("FAIL rand%0d_counts got %0d/%0d expected %0d/%0d", it, obs_addr.size(), obs_clr.size(), exp_addr.size(), exp_clr.size());
         end
         for (int k = 0; k < obs_addr.size() && k < exp_addr.size(); k++) begin
            checks++;
            if (obs_addr[k] !== exp_addr[k] || obs_data[k] !== exp_data[k]) begin
               errors++; $display("FAIL rand%0d_write%0d got %h expected %h", it, k, obs_addr[k], exp_addr[k]);
            end
         end
         for (int k = 0; k < obs_clr.size() && k < exp_clr.size(); k++) begin
            checks++;
            if (obs_clr[k] !== exp_clr[k]) begin
               errors++; $display("FAIL rand%0d_clear%0d got %0d expected %0d", it, k, obs_clr[k], exp_clr[k]);
            end
         end
         checks++;
         if (done_cyc !== exp_cyc || tot_w !== exp_w || done_cnt !== 1) begin
            errors++; $display("FAIL rand%0d_timing got done %0d writes %0d expected %0d %0d", it, done_cyc, tot_w, exp_cyc, exp_w);
         end
         checks++;
         if (busy_gap !== 0 || unstable !== 0 || first_idx !== 0 || post_busy !== 1'b0 || post_done !== 1'b0) begin
            errors++; $display("FAIL rand%0d_misc got gap %0d unstable %0d first %0d post %b/%b expected 0 0 0 0/0", it, busy_gap, unstable, first_idx, post_busy, post_done);
         end
      end
   endtask

   task automatic test_back_to_back();
      int dones [$];
      int idles [$];
      bit drained;
      dirty_bits = 8'h00;
      pmem_resp  = 1'b0;
      @(negedge clk);
      flush_req = 1'b1;
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         if (flush_done === 1'b1) dones.push_back(c);
         if (busy !== 1'b1) idles.push_back(c);
      end
      flush_req = 1'b0;
      checks++;
      if (dones.size() !== 2 || dones[0] !== 9 || dones[1] !== 19) begin
         errors++; $display("FAIL b2b_done got %0d pulses first %0d expected 2 at 9,19", dones.size(), (dones.size() > 0) ? dones[0] : -1);
      end
      checks++;
      if (idles.size() !== 2 || idles[0] !== 10 || idles[1] !== 20) begin
         errors++; $display("FAIL b2b_idle got %0d idle cycles first %0d expected 2 at 10,20", idles.size(), (idles.size() > 0) ? idles[0] : -1);
      end
      drained = 1'b0;
      for (int c = 0; c < 30 && !drained; c++) begin
         @(negedge clk);
         if (busy === 1'b0) drained = 1'b1;
      end
      checks++;
      if (!drained) begin
         errors++; $display("FAIL b2b_drain got busy stuck expected idle within 30 cycles");
      end
   endtask

   task automatic test_reset_mid_write();
      bit seen;
      int bad;
      fill_random();
      dirty_bits = 8'b0010_0000;
      pmem_resp  = 1'b0;
      seen = 1'b0;
      @(negedge clk);
      flush_req = 1'b1;
      @(negedge clk);
      flush_req = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
         if (pmem_write === 1'b1) seen = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!seen || array_index !== 3'd5) begin
         errors++; $display("FAIL rstw_reach got write %b index %0d expected 1 5", seen, array_index);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (pmem_write !== 1'b0 || busy !== 1'b0 || clear_dirty !== 1'b0 || pmem_address !== 16'h0000) begin
         errors++; $display("FAIL rstw_async got write %b busy %b clr %b addr %h expected 0 0 0 0000", pmem_write, busy, clear_dirty, pmem_address);
      end
      @(negedge clk);
      reset_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (flush_done !== 1'b0 || clear_dirty !== 1'b0 || busy !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL rstw_quiet got %0d active cycles expected 0", bad);
      end
      model_flush(1);
      do_flush(1, 1'b0, 1'b0);
      checks++;
      if (first_idx !== 0 || obs_addr.size() !== 1 || done_cyc !== exp_cyc) begin
         errors++; $display("FAIL rstw_restart got first %0d writes %0d done %0d expected 0 1 %0d", first_idx, obs_addr.size(), done_cyc, exp_cyc);
      end
      checks++;
      if (obs_addr.size() > 0 && obs_addr[0] !== exp_addr[0]) begin
         errors++; $display("FAIL rstw_addr got %h expected %h", obs_addr[0], exp_addr[0]);
      end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_single_dirty();
      test_all_dirty();
      test_random();
      test_back_to_back();
      test_reset_mid_write();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
